// File: rtl/General.sv
// Shared seven-segment helpers: nibble type, special glyph codes,
// active-low segment decode and a width helper for counters.
package General;

  typedef logic [3:0] uint4_t;

  localparam uint4_t Minus = 4'hA;
  localparam uint4_t Empty = 4'hF;

  // Minimum of 1 so that a degenerate count of 1 still yields a legal vector.
  function automatic int clog2(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

  // Segment order {dp, g, f, e, d, c, b, a}, active low.
  function automatic logic [7:0] BCD2ESC(input uint4_t code);
    case (code)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      Minus:   return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_scanner_pkg.sv
// Block-local types for the seven-segment scanner.
package seg_display_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FMT
  } state_e;

endpackage

// File: rtl/seg_display_scanner_if.sv
// Load request, status and display outputs of the seven-segment scanner.
interface seg_display_scanner_if #(
  parameter int DIGITS = 4,
  parameter int DATA_W = 16
);
  logic              load;
  logic [DATA_W-1:0] value;
  logic              blank_zeros;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [7:0]        seg;
  logic [DIGITS-1:0] an;

  modport master (
    output load, value, blank_zeros,
    input  busy, done, ovf, seg, an
  );

  modport slave (
    input  load, value, blank_zeros,
    output busy, done, ovf, seg, an
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one input bit per cycle for DATA_W cycles.
// done is high during the final step; bcd holds the result from the next cycle.
module bin2bcd_seq
  import General::*;
#(
  parameter int DATA_W = 16,
  parameter int BCD_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);
  localparam int STEP_W = clog2(DATA_W);

  logic              active_q, active_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    active_d = active_q;
    step_d   = step_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    done     = active_q && (step_q == STEP_W'(DATA_W - 1));

    if (start) begin
      active_d = 1'b1;
      step_d   = '0;
      shift_d  = bin;
      bcd_d    = '0;
    end else if (active_q) begin
      bcd_d   = {adj[BCD_W-2:0], shift_q[DATA_W-1]};
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
      step_d  = step_q + 1'b1;
      if (done) active_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      step_q   <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
    end else begin
      active_q <= active_d;
      step_q   <= step_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/seg_display_scanner.sv
// Signed value to multiplexed seven-segment display: load/convert/format FSM
// plus a free-running digit scanner over the committed display buffer.
module seg_display_scanner
  import General::*;
  import seg_display_scanner_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 50000
) (
  input logic                 clk,
  input logic                 rst,
  seg_display_scanner_if.slave bus
);
  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int CNT_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(DIGITS);

  state_e            state_q, state_d;
  logic              neg_q, neg_d;
  logic              blank_q, blank_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  uint4_t            disp_q [DIGITS];
  uint4_t            disp_d [DIGITS];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic              conv_start;
  logic              conv_done;
  logic [DATA_W-1:0] mag;
  logic [BCD_W-1:0]  bcd;
  uint4_t            fmt [DIGITS];
  logic              fmt_ovf;
  int                msnz;

  // Unsigned negation keeps -2^(DATA_W-1) as 2^(DATA_W-1) in DATA_W bits.
  assign mag = bus.value[DATA_W-1] ? (~bus.value + 1'b1) : bus.value;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .BCD_W  (BCD_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // A negative number gives up the top digit to the minus sign.
  always_comb begin
    fmt_ovf = neg_q ? (bcd[BCD_W-1 -: 8] != 8'd0) : (bcd[BCD_W-1 -: 4] != 4'd0);
    msnz = 0;
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msnz = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (fmt_ovf)                   fmt[i] = Minus;
      else if (blank_q && i > msnz)  fmt[i] = (neg_q && i == msnz + 1) ? Minus : Empty;
      else                           fmt[i] = bcd[4*i +: 4];
    end
    if (!fmt_ovf && neg_q && !blank_q) fmt[DIGITS-1] = Minus;
  end

  always_comb begin
    state_d    = state_q;
    neg_d      = neg_q;
    blank_d    = blank_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    conv_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          conv_start = 1'b1;
          neg_d      = bus.value[DATA_W-1];
          blank_d    = bus.blank_zeros;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (conv_done) state_d = FMT;
      end
      FMT: begin
        disp_d  = fmt;
        ovf_d   = fmt_ovf;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scanner runs independently of commits; outputs lag index/buffer by one cycle.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    seg_d = BCD2ESC(disp_q[idx_q]);
    an_d  = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      blank_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      // NOTE: the display buffer is a handful of flops, not a RAM, so it is
      // reset to Empty to keep the display dark until the first commit.
      disp_q  <= '{default: Empty};
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      blank_q <= blank_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.seg  = seg_q;
  assign bus.an   = an_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench: loads push model expectations, a negedge monitor checks
// commits, ovf and every scanned seg/an value.
module tb_seg_display_scanner;

  localparam int DIGITS   = 4;
  localparam int DATA_W   = 16;
  localparam int SCAN_DIV = 4;

  typedef struct {
    logic [8*DIGITS-1:0] segs;
    bit                  ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_display_scanner_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

  seg_display_scanner #(
    .DIGITS   (DIGITS),
    .DATA_W   (DATA_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'b1100_0000;
      1: return 8'b1111_1001;
      2: return 8'b1010_0100;
      3: return 8'b1011_0000;
      4: return 8'b1001_1001;
      5: return 8'b1001_0010;
      6: return 8'b1000_0010;
      7: return 8'b1111_1000;
      8: return 8'b1000_0000;
      9: return 8'b1001_0000;
      default: return 8'hFF;
    endcase
  endfunction

  localparam logic [7:0] SEG_MINUS = 8'b1011_1111;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Decimal reference: digit positions come from integer division.
  function automatic exp_t model(input int v, input bit blank);
    exp_t e;
    int mag, nd, p, d;
    bit neg;
    logic [7:0] g;
    neg   = (v < 0);
    mag   = neg ? -v : v;
    e.ovf = neg ? (mag > 999) : (mag > 9999);
    nd = 1;
    p  = 10;
    while (mag >= p) begin
      nd++;
      p *= 10;
    end
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = (mag / p) % 10;
      p *= 10;
      if (e.ovf)                g = SEG_MINUS;
      else if (!blank)          g = (neg && i == DIGITS - 1) ? SEG_MINUS : glyph(d);
      else if (i < nd)          g = glyph(d);
      else if (neg && i == nd)  g = SEG_MINUS;
      else                      g = SEG_BLANK;
      e.segs[8*i +: 8] = g;
    end
    return e;
  endfunction

  // Monitor: expected display contents and scan position since reset release.
  logic [8*DIGITS-1:0] disp_exp = '1;
  bit                  ovf_exp  = 1'b0;
  int                  n_cyc    = 0;
  int                  m_idx;
  logic [7:0]          m_seg;
  logic [DIGITS-1:0]   m_an;
  exp_t                m_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      disp_exp = '1;
      ovf_exp  = 1'b0;
      n_cyc    = 0;
      check("rst_an",   32'(bus.an),   32'hF);
      check("rst_seg",  32'(bus.seg),  32'hFF);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_ovf",  32'(bus.ovf),  32'h0);
    end else begin
      if (n_cyc == 0) begin
        m_an  = '1;
        m_seg = 8'hFF;
      end else begin
        m_idx = ((n_cyc - 1) / SCAN_DIV) % DIGITS;
        m_an  = 4'hF ^ (4'h1 << m_idx);
        m_seg = disp_exp[8*m_idx +: 8];
      end
      check("scan_an",  32'(bus.an),  32'(m_an));
      check("scan_seg", 32'(bus.seg), 32'(m_seg));
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'h0);
        end else begin
          m_e      = exp_q.pop_front();
          disp_exp = m_e.segs;
          ovf_exp  = m_e.ovf;
        end
      end
      check("ovf", 32'(bus.ovf), 32'(ovf_exp));
      n_cyc++;
    end
  end

  // One load; optionally a second load while busy, or a reset mid-conversion.
  task automatic do_load(input int v, input bit blank, input bit extra, input bit rst_mid);
    int lat;
    @(posedge clk);
    #1;
    bus.load        = 1'b1;
    bus.value       = DATA_W'(v);
    bus.blank_zeros = blank;
    exp_q.push_back(model(v, blank));
    @(posedge clk);
    #1;
    bus.load        = 1'b0;
    bus.value       = DATA_W'($urandom);
    bus.blank_zeros = 1'($urandom);
    check("busy_after_load", 32'(bus.busy), 32'h1);
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (extra && lat == 5) begin
        bus.load  = 1'b1;
        bus.value = DATA_W'($urandom);
      end else begin
        bus.load  = 1'b0;
      end
      if (rst_mid && lat == 10) begin
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(bus.busy), 32'h0);
        check("rst_mid_seg",  32'(bus.seg),  32'hFF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) begin
          @(posedge clk);
          #1;
        end
        return;
      end
    end
    if (!bus.done) check("done_timeout", 32'(lat), 32'(DATA_W + 2));
    else           check("latency", 32'(lat), 32'(DATA_W + 2));
    check("busy_at_done", 32'(bus.busy), 32'h0);
    repeat ($urandom_range(0, 20)) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int rv;

  initial begin
    bus.load        = 1'b0;
    bus.value       = '0;
    bus.blank_zeros = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);

    do_load(1234, 1'b0, 1'b0, 1'b0);
    do_load(-42, 1'b1, 1'b0, 1'b0);
    do_load(12345, 1'b0, 1'b0, 1'b0);
    do_load(-1000, 1'b1, 1'b0, 1'b0);
    do_load(7, 1'b1, 1'b0, 1'b0);
    do_load(-32768, 1'b0, 1'b0, 1'b0);
    do_load(0, 1'b1, 1'b0, 1'b0);
    do_load(0, 1'b0, 1'b0, 1'b0);
    do_load(9999, 1'b1, 1'b0, 1'b0);
    do_load(10000, 1'b1, 1'b0, 1'b0);
    do_load(-999, 1'b1, 1'b0, 1'b0);
    do_load(-999, 1'b0, 1'b0, 1'b0);
    do_load(-1, 1'b1, 1'b0, 1'b0);
    do_load(32767, 1'b0, 1'b0, 1'b0);
    do_load(305, 1'b1, 1'b1, 1'b0);
    do_load(4321, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 24; k++) begin
      rv = $urandom_range(0, 3);
      case (rv)
        0:       do_load($signed(16'($urandom)), 1'($urandom), 1'($urandom), 1'b0);
        1:       do_load($urandom_range(0, 9999), 1'($urandom), 1'($urandom), 1'b0);
        default: do_load(-int'($urandom_range(0, 1200)), 1'($urandom), 1'($urandom), 1'b0);
      endcase
    end

    repeat (20) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 Parameter DIGITS, default 4, number of seven-segment digits driven.
REQ-002 Parameter DATA_W, default 16, width of the signed input value.
REQ-003 Parameter SCAN_DIV, default 50000, clock cycles each digit stays lit.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 load  in  1  one-cycle request to convert and show value.
REQ-007 value  in  DATA_W  two's-complement number to display.
REQ-008 blank_zeros  in  1  1 = leading zeros shown as Empty; sampled with load.
REQ-009 busy  out  1  conversion in progress; load ignored while high.
REQ-010 done  out  1  one-cycle pulse when the new display buffer is committed.
REQ-011 ovf  out  1  last accepted value did not fit; held until next commit.
REQ-012 seg  out  8  active-low segment code of the lit digit, bit 7 = dp.
REQ-013 an  out  DIGITS  active-low one-hot digit enable, bit 0 = rightmost digit.

Function
REQ-014 FSM states IDLE, CONV and FMT; load in IDLE captures value and blank_zeros and moves to CONV next edge.
REQ-015 Negative value: sign flag set, magnitude = two's-complement negation in DATA_W bits unsigned; -2^(DATA_W-1) is handled without overflow of the magnitude register.
REQ-016 CONV runs shift-add-3 (double dabble), one bit per cycle, exactly DATA_W cycles, into a 4*(DIGITS+1)-bit BCD register.
REQ-017 FMT (1 cycle) builds the DIGITS-entry buffer of 4-bit codes, then commits it atomically to the display buffer and returns to IDLE.
REQ-018 busy is high from the edge after load through the FMT cycle; done is high in the cycle immediately after FMT; total load-to-done = DATA_W+2 cycles.
REQ-019 load while busy is ignored: no capture, no restart, no flag.
REQ-020 Positive fit limit 10^DIGITS-1; negative fit limit 10^(DIGITS-1)-1 in magnitude; beyond limit: every digit = Minus, ovf=1.
REQ-021 Digit 0 always shows its BCD value, including zero.
REQ-022 blank_zeros=1: zero digits left of the most significant nonzero digit become Empty; minus sign goes in the digit immediately left of that digit.
REQ-023 blank_zeros=0: leading zeros shown; minus sign goes in digit DIGITS-1.
REQ-024 Scan counter counts 0..SCAN_DIV-1; at terminal count the digit index advances, wrapping DIGITS-1 -> 0.
REQ-025 seg and an are registered: they reflect the index and display buffer of the previous cycle; seg = BCD2ESC of the buffer entry.
REQ-026 The display buffer commit does not reset the scan counter or index; scan timing is continuous.
REQ-027 A commit and a scan index step in the same cycle are both taken; the next seg uses the new buffer.

Reset
REQ-028 On rst: FSM IDLE, busy=0, done=0, ovf=0, scan counter=0, index=0, display buffer all Empty, an all ones, seg 8'hFF.
REQ-029 rst during CONV or FMT discards the conversion; no done pulse follows.
REQ-030 First digit enable appears the cycle after rst deasserts (an bit 0 low).

Structure
REQ-031 uint4_t, Minus, Empty, BCD2ESC and clog2 (counter/index widths) come from shared package General; no local duplicates.
REQ-032 Sub-module bin2bcd_seq holds the double-dabble sequencer (start/done handshake); the top holds the FSM, formatter and scan logic.

Verification (DIGITS=4, DATA_W=16, SCAN_DIV=4)
REQ-033 load value=1234, blank_zeros=0 -> done 18 cycles later; digits 1,2,3,4; with index 0 lit, seg=1001_1001.
REQ-034 load value=-42, blank_zeros=1 -> digits Empty,Minus,4,2; with index 2 lit, seg=1011_1111; ovf=0.
REQ-035 load 12345, then -1000 -> each commit shows all four digits 1011_1111 with ovf=1; load 7 clears ovf.
REQ-036 Idle after reset -> an cycles 1110,1101,1011,0111, each held 4 clocks, then repeats.
REQ-037 Second load 5 cycles after the first -> ignored; one done only; buffer matches the first value.
REQ-038 rst asserted 10 cycles into CONV -> outputs at reset values immediately; no done; buffer all Empty (seg 8'hFF).
